// File: rtl/int_ctrl_if.sv
`timescale 1ns/1ps
// int_ctrl_if -- register bus between the MIO decoder and int_ctrl.
//
// Signals
//   addr     [3:0]  byte offset; addr[3:2] selects the register
//   we              write strobe, already decoded for this block
//   data_in  [31:0] CPU write data
//   data_out [31:0] register read data (combinational from addr)
//
// Modports
//   master : bus side (drives addr/we/data_in, reads data_out)
//   slave  : int_ctrl side
interface int_ctrl_if;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output addr, output we, output data_in, input data_out);
  modport slave  (input addr, input we, input data_in, output data_out);
endinterface

// File: rtl/int_ctrl.sv
`timescale 1ns/1ps
// int_ctrl -- six-source interrupt controller with PENDING / MASK / EDGE / ID
// registers on a small MIO register bus.
//
// Ports
//   clk      single clock, rising-edge
//   RSTN     asynchronous active-low reset
//   src[5:0] interrupt sources, bit 0 highest priority
//   bus      int_ctrl_if.slave register bus (addr, we, data_in, data_out)
//   int_     PENDING & MASK, to the CPU interrupt input
//   irq_any  OR of int_
//
// Register map (addr[3:2])
//   0x0 PENDING  read, write-1-to-clear (edge-mode bits only)
//   0x4 MASK     read/write
//   0x8 EDGE     read/write, 1 = rising-edge capture, 0 = level tracking
//   0xC ID       read only: {1, 28'b0, lowest active int_ index}, 0 if none
//
// Build option
//   INT_CTRL_SYNC_EN  when defined, each src bit passes through a two-flop
//                     synchronizer before edge/level capture; otherwise src
//                     is used as-is.
module int_ctrl (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [5:0]       src,
  int_ctrl_if.slave        bus,
  output logic [5:0]       int_,
  output logic             irq_any
);

  localparam int NSRC = 6;

  logic [NSRC-1:0] cond;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_en;

  // ---- stage p0/p1: source conditioning ----
`ifdef INT_CTRL_SYNC_EN
  logic [NSRC-1:0] sync_p0;
  logic [NSRC-1:0] sync_p1;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
    end
  end

  assign cond = sync_p1;
`else
  assign cond = src;
`endif

  // ---- register decode ----
  logic wr_pend;
  logic wr_mask;
  logic wr_edge;

  assign wr_pend = bus.we && (bus.addr[3:2] == 2'd0);
  assign wr_mask = bus.we && (bus.addr[3:2] == 2'd1);
  assign wr_edge = bus.we && (bus.addr[3:2] == 2'd2);

  // addr[1:0] and data_in[31:6] carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.data_in[31:NSRC]};

  // ---- capture logic ----
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_nxt;

  assign clr  = wr_pend ? bus.data_in[NSRC-1:0] : '0;
  assign rise = cond & ~prev;

  // Edge-mode bits: a new rise is OR-ed in after the clear, so set wins.
  // Level-mode bits follow the conditioned source and ignore W1C.
  assign pend_nxt = (edge_en & ((pend & ~clr) | rise)) | (~edge_en & cond);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      prev    <= '0;
      pend    <= '0;
      mask    <= '0;
      edge_en <= '0;
    end else begin
      prev <= cond;
      pend <= pend_nxt;
      if (wr_mask) mask    <= bus.data_in[NSRC-1:0];
      if (wr_edge) edge_en <= bus.data_in[NSRC-1:0];
    end
  end

  // ---- outputs ----
  assign int_    = pend & mask;
  assign irq_any = |int_;

  // Lowest active index wins; scan from the top so the last hit is the lowest.
  logic [2:0] id_idx;
  always_comb begin
    id_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (int_[i]) id_idx = 3'(i);
    end
  end

  logic [31:0] id_word;
  assign id_word = irq_any ? {1'b1, 28'd0, id_idx} : 32'd0;

  always_comb begin
    bus.data_out = 32'd0;
    case (bus.addr[3:2])
      2'd0:    bus.data_out = {26'd0, pend};
      2'd1:    bus.data_out = {26'd0, mask};
      2'd2:    bus.data_out = {26'd0, edge_en};
      default: bus.data_out = id_word;
    endcase
  end

endmodule
